ahb_data_mem_slave: RTL
=======================

// Module: ahb_data_mem_slave
// PURPOSE
//  AHB-Lite responder (slave) for the data-memory port. Pairs with the decode-stage
//  transfer controls (start/htrans/hsize) issued for LB/LH/LW/LBU/LHU/SB/SH/SW.
//  Holds a word-organised, little-endian RAM and adds programmable wait states.
//  Returns full read words; the core does the byte/halfword extraction and extension.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 b
//  WAIT_STATES  1   data-phase stall cycles per NONSEQ/SEQ transfer (0..15)
// PORTS
//  HCLK       in   1   bus clock; all state updates on its rising edge
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select
//  HADDR      in   32  byte address; bits [ADDR_WIDTH+1:2] index the RAM, upper bits ignored
//  HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWRITE     in   1   1 = write, 0 = read
//  HSIZE      in   3   000 byte, 001 halfword, 010 word
//  HWDATA     in   32  write data, valid in the data phase
//  HREADY     in   1   bus ready; qualifies the address phase
//  HREADYOUT  out  1   0 = stall the current data phase
//  HRDATA     out  32  read data; valid when HREADYOUT=1 in a read data phase, else 0
//  HRESP      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  - Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
//    RAM contents are not reset. Assertion of HRESETn mid-transfer aborts the
//    transfer; a write is not committed unless its final data-phase edge has passed.
//  - Address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register
//    word index, byte offset HADDR[1:0], HSIZE and HWRITE. Load the counter with WAIT_STATES.
//  - IDLE/BUSY transfers, or HSEL=0 with HREADY=1: zero-wait OKAY. No RAM access.
//  - FSM:
//    IDLE -> WAIT on an accepted transfer when WAIT_STATES>0; IDLE -> DATA when WAIT_STATES=0.
//    WAIT: HREADYOUT=0. Decrement the counter; go to DATA when the counter reaches 1.
//    DATA: HREADYOUT=1. This is the final data-phase cycle. Return to IDLE, or go directly
//    to WAIT/DATA if a new address phase is accepted in this same cycle (back-to-back).
//  - Latency: the read/write data phase is WAIT_STATES+1 cycles after the address phase.
//  - Reads: HRDATA = RAM[index], read combinationally in the DATA cycle.
//  - Writes: HWDATA is sampled in the DATA cycle and committed at the end of that cycle.
//    A read whose data phase immediately follows sees the new value (no stale data).
//  - Byte lanes (little-endian), written on write only:
//    byte -> lane HADDR[1:0]; half -> lanes {HADDR[1],0} and {HADDR[1],1}; word -> all 4 lanes.
//    Untouched lanes keep their previous value.
//  - Accesses with HSIZE > 010 are treated as word accesses when the macro is off.
//  - Misaligned halfword/word accesses, with the macro off: the low address bits are
//    forced to alignment (half: bit0=0; word: bits[1:0]=0) and the response is OKAY.
// CONFIGURATION
//  AHB_MEM_ERR_RESP_EN defined:
//    - Misaligned accesses and HSIZE > 010 get a two-cycle ERROR response after the
//      wait states: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
//    - No RAM write occurs and HRDATA=0.
//    - A new address phase sampled during ERR2 is accepted normally.
//  Not defined: alignment is forced as above, HRESP is tied to 0, and no ERR states exist.
// TESTING
//  1 Reset: HRESETn=0 with bus active -> HREADYOUT=1, HRESP=0, HRDATA=0.
//    After release, IDLE transfers get a zero-wait OKAY.
//  2 WAIT_STATES=1: SW 0xDEADBEEF @0x10, then LW @0x10 back-to-back.
//    -> Each data phase has exactly 1 cycle with HREADYOUT=0; the LW returns 0xDEADBEEF.
//  3 Lanes: SW 0x11223344 @0x20; SB 0xAA @0x21; SH 0xBBCC @0x22.
//    -> A following LW @0x20 returns 0xBBCCAA44.
//  4 WAIT_STATES=0: alternate SW/LW to 0x0, 0x4, 0x3FFC every cycle.
//    -> HREADYOUT stays 1; each read returns the value just written.
//    -> Address 0x1000 aliases to 0x0 (ADDR_WIDTH=10).
//  5 Macro on: LW @0x2 -> ERR1 then ERR2 with HRESP=1, RAM unchanged.
//    Macro off: the same LW returns the word @0x0.
//  6 Reset mid-WAIT of SW @0x8 (old value 0x5) -> after reset, LW @0x8 returns 0x5.

Source files
------------

// File: rtl/ahb_data_mem_slave.sv
// ahb_data_mem_slave: AHB-Lite data-memory responder, little-endian word RAM with wait states.
// Define AHB_MEM_ERR_RESP_EN to answer misaligned/oversized transfers with a two-cycle ERROR.
module ahb_data_mem_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);
`ifdef AHB_MEM_ERR_RESP_EN
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_e;
`endif
    state_e                state_q, state_d, fin_q, fin_new;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            off_q, off_d, sz_q, sz_d, sz_in, off_in;
    logic                  write_q, write_d, ready_q, ready_d, accept, can_accept, stall_d;
    logic [3:0]            cnt_q, cnt_d, be;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  unused;
    assign unused = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
    // Sizes above word collapse to word; low address bits are forced to natural alignment.
    assign sz_in  = (HSIZE[2] || HSIZE[1:0] == 2'b11) ? 2'd2 : HSIZE[1:0];
    assign off_in = sz_in == 2'd0 ? HADDR[1:0] : sz_in == 2'd1 ? {HADDR[1], 1'b0} : 2'b00;
`ifdef AHB_MEM_ERR_RESP_EN
    logic err_q, err_d, resp_q, resp_d, bad;
    assign bad        = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign fin_q      = err_q ? ERR1 : DATA;
    assign fin_new    = bad ? ERR1 : DATA;
    assign can_accept = state_q != WAIT && state_q != ERR1;
    assign stall_d    = state_d == WAIT || state_d == ERR1;
    assign resp_d     = state_d == ERR1 || state_d == ERR2;
    assign err_d      = accept ? bad : err_q;
    assign HRESP      = resp_q;
`else
    assign fin_q      = DATA;
    assign fin_new    = DATA;
    assign can_accept = state_q != WAIT;
    assign stall_d    = state_d == WAIT;
    assign HRESP      = 1'b0;
`endif
    assign accept  = HSEL && HTRANS[1] && HREADY && can_accept;
    assign ready_d = !stall_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        sz_d    = sz_q;
        write_d = write_q;
        if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = fin_q;
        end else if (state_q == DATA) begin
            state_d = IDLE;
        end
`ifdef AHB_MEM_ERR_RESP_EN
        else if (state_q == ERR1) state_d = ERR2;
        else if (state_q == ERR2) state_d = IDLE;
`endif
        if (accept) begin
            idx_d   = HADDR[ADDR_WIDTH+1:2];
            off_d   = off_in;
            sz_d    = sz_in;
            write_d = HWRITE;
            cnt_d   = 4'(WAIT_STATES);
            state_d = (WAIT_STATES > 0) ? WAIT : fin_new;
        end
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            sz_q    <= '0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef AHB_MEM_ERR_RESP_EN
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            sz_q    <= sz_d;
            write_q <= write_d;
            ready_q <= ready_d;
`ifdef AHB_MEM_ERR_RESP_EN
            err_q   <= err_d;
            resp_q  <= resp_d;
`endif
        end
    end
    assign be = sz_q == 2'd0 ? 4'b0001 << off_q : sz_q == 2'd1 ? (off_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // Commit at the end of the DATA cycle, so a read data phase right after sees the new word.
    always_ff @(posedge HCLK) begin
        if (state_q == DATA && write_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
    assign HRDATA    = (state_q == DATA && !write_q) ? mem[idx_q] : '0;
    assign HREADYOUT = ready_q;
endmodule
